// File: rtl/fpga_cmd_rx.sv
// fpga_cmd_rx
// -----------------------------------------------------------------------------
// SPI command receiver running entirely in the 13.56 MHz domain. The ARM's
// spck/mosi/ncs lines are oversampled through synchronizers. A frame framed by
// ncs is shifted in MSB first on synchronized spck rising edges, and a 16-bit
// command is decoded into the configuration register or the LF divisor.
//
// Handshake / pulse semantics: there is no ready/valid pair. Every register
// update is accompanied by exactly one single-cycle pulse (conf_strobe,
// div_strobe, frame_err or cmd_err). The pulse is high in the same cycle the
// new register value first appears, and at most one pulse is high at a time.
//
// Ports:
//   ck_1356meg   in   system clock, all state on its rising edge
//   nreset       in   asynchronous active-low reset
//   spck         in   SPI clock (asynchronous)
//   mosi         in   SPI data, MSB first, sampled on spck rising edge
//   ncs          in   SPI chip select, active low, frames one command
//   conf_word    out  configuration register, [7:5] = major mode
//   divisor      out  LF divisor register
//   conf_strobe  out  pulse when conf_word takes a new value
//   div_strobe   out  pulse when divisor takes a new value
//   frame_err    out  pulse when a frame ends with the wrong bit count
//   cmd_err      out  pulse when a full-length frame has an unknown opcode
//   state_dbg    out  current receiver state (IDLE=0, SHIFT=1, DECODE=2)
// -----------------------------------------------------------------------------
module fpga_cmd_rx #(
    parameter int CMD_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       conf_strobe,
    output logic       div_strobe,
    output logic       frame_err,
    output logic       cmd_err,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = $clog2(CMD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(CMD_BITS + 1);

    localparam logic [3:0] OP_CONF = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    // Synchronizers; index SYNC_STAGES-1 is the synchronized (*_s) value.
    logic [SYNC_STAGES-1:0] spck_sync_q, spck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic                   spck_dly_q,  spck_dly_d;
    logic                   ncs_dly_q,   ncs_dly_d;

    // Fill tracker: the top bit is set once ncs_dly holds a real pin sample
    // rather than the reset value. It keeps a chip select that was already low
    // coming out of reset from looking like a falling edge.
    logic [SYNC_STAGES:0]   fill_q, fill_d;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CMD_BITS-1:0]    shreg_q, shreg_d;
    logic [7:0]             conf_q, conf_d;
    logic [7:0]             div_q, div_d;
    logic                   conf_stb_q, conf_stb_d;
    logic                   div_stb_q, div_stb_d;
    logic                   frame_err_q, frame_err_d;
    logic                   cmd_err_q, cmd_err_d;

    logic spck_s, mosi_s, ncs_s;
    logic spck_rise, ncs_rise, ncs_fall;

    assign spck_s = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    assign spck_rise = !spck_dly_q && spck_s;
    assign ncs_rise  = !ncs_dly_q && ncs_s;
    assign ncs_fall  = fill_q[SYNC_STAGES] && ncs_dly_q && !ncs_s;

    always_comb begin
        spck_sync_d = {spck_sync_q[SYNC_STAGES-2:0], spck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        spck_dly_d  = spck_s;
        ncs_dly_d   = ncs_s;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};

        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        conf_d      = conf_q;
        div_d       = div_q;
        conf_stb_d  = 1'b0;
        div_stb_d   = 1'b0;
        frame_err_d = 1'b0;
        cmd_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                // ncs deassertion wins over a coincident spck edge.
                if (ncs_rise) begin
                    state_d = DECODE;
                end else if (spck_rise) begin
                    shreg_d = {shreg_q[CMD_BITS-2:0], mosi_s};
                    if (cnt_q != CNT_OVR) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (cnt_q != CNT_FULL) begin
                    frame_err_d = 1'b1;
                end else if (shreg_q[CMD_BITS-1 -: 4] == OP_CONF) begin
                    conf_d     = shreg_q[7:0];
                    conf_stb_d = 1'b1;
                end else if (shreg_q[CMD_BITS-1 -: 4] == OP_DIV) begin
                    div_d     = shreg_q[7:0];
                    div_stb_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_dly_q  <= 1'b0;
            ncs_dly_q   <= 1'b1;
            fill_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            conf_q      <= 8'hE0;
            div_q       <= 8'd95;
            conf_stb_q  <= 1'b0;
            div_stb_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            spck_sync_q <= spck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            spck_dly_q  <= spck_dly_d;
            ncs_dly_q   <= ncs_dly_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            conf_q      <= conf_d;
            div_q       <= div_d;
            conf_stb_q  <= conf_stb_d;
            div_stb_q   <= div_stb_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign conf_word   = conf_q;
    assign divisor     = div_q;
    assign conf_strobe = conf_stb_q;
    assign div_strobe  = div_stb_q;
    assign frame_err   = frame_err_q;
    assign cmd_err     = cmd_err_q;
    assign state_dbg   = state_q;

endmodule

// File: doc/fpga_cmd_rx.md
# fpga_cmd_rx

Synchronous SPI command receiver for the FPGA top level. It oversamples the ARM's SPI lines (spck, mosi, ncs) in the 13.56 MHz domain, assembles 16-bit command words, and decodes them into the configuration register (major mode and sub-mode bits) and the LF clock divisor. It sits directly upstream of the major-mode muxes and mode modules, which consume `conf_word` and `divisor`. It replaces the free-running spck/ncs-clocked shifter so that all configuration state changes on a single clock, glitch-free.

## Interface

Parameters:
- `CMD_BITS`, 16: command word length in bits.
- `SYNC_STAGES`, 2: synchronizer depth on spck, mosi and ncs. Minimum 2.

Ports:
- `ck_1356meg`  in  1  system clock, 13.56 MHz; all state is on its rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `spck`  in  1  SPI clock from the ARM. Asynchronous input.
- `mosi`  in  1  SPI data, MSB first, sampled on the spck rising edge.
- `ncs`  in  1  SPI chip select, active low, framing one command.
- `conf_word`  out  8  configuration register. Bits [7:5] are major_mode.
- `divisor`  out  8  LF divisor register.
- `conf_strobe`  out  1  one-cycle pulse in the cycle `conf_word` takes its new value.
- `div_strobe`  out  1  one-cycle pulse in the cycle `divisor` takes its new value.
- `frame_err`  out  1  one-cycle pulse when a frame ends with a bit count other than CMD_BITS.
- `cmd_err`  out  1  one-cycle pulse when a correctly sized frame carries an unknown opcode.

## Operation

- **Synchronization.** spck, mosi and ncs each pass through SYNC_STAGES flops (`*_s`). One further flop per line (`*_d`) is used for edge detection. All three lines take identical delay, so mosi_s is aligned with spck_s.
- **States:** IDLE, SHIFT, DECODE.
  - After reset, the state is IDLE.
  - IDLE → SHIFT on an ncs_s falling edge (ncs_d=1, ncs_s=0). If ncs is already low out of reset, stay in IDLE until ncs has gone high and then low again. A partial frame is never accepted.
  - Entering SHIFT clears the bit counter and the shift register.
  - SHIFT, on each spck_s rising edge (spck_d=0, spck_s=1): `shift_reg <= {shift_reg[14:0], mosi_s}` and the bit counter increments.
    - The counter is 5 bits and saturates at 17, meaning overrun.
    - Once the count is ≥16, further edges still shift, so the last 16 bits are kept. Count 17 flags the overrun.
  - SHIFT → DECODE on an ncs_s rising edge.
    - If an spck_s rising edge occurs in the same cycle, it is ignored, because ncs is already deasserted.
  - DECODE lasts exactly one cycle, then → IDLE.
- **Decode** (registered at the end of the DECODE cycle):
  - Count ≠ 16: pulse `frame_err`; no register changes.
  - Count = 16, shift_reg[15:12] = 4'b0001: `conf_word <= shift_reg[7:0]`, pulse `conf_strobe`.
  - Count = 16, shift_reg[15:12] = 4'b0010: `divisor <= shift_reg[7:0]`, pulse `div_strobe`.
  - Count = 16, any other opcode: pulse `cmd_err`; no register changes.
  - shift_reg[11:8] is ignored.
- Writing the same value again still pulses the corresponding strobe.
- **Reset values:**
  - `conf_word` = 8'hE0 (major mode 111, everything off).
  - `divisor` = 8'd95.
  - All strobes and error pulses are 0.
  - state = IDLE, counter = 0, shift_reg = 0.
  - All synchronizer and edge flops reset to 1 for ncs and 0 for spck/mosi.
- Reset asserted mid-frame aborts the frame immediately. No partial update survives; outputs return to reset values asynchronously.

## Timing

- **Input requirements:** spck high time ≥2 ck periods and low time ≥2 ck periods. mosi must be stable from 1 period before to 2 periods after each spck rising edge. ncs must stay high ≥3 periods between frames.
- **Latency:**
  - An ncs pin rising at clock edge k reaches ncs_s at edge k+SYNC_STAGES.
  - DECODE is entered at edge k+SYNC_STAGES+1.
  - `conf_word`/`divisor` and the strobes update at edge k+SYNC_STAGES+2, which is k+4 with defaults.
- Strobes and error pulses are high for exactly one cycle. They are mutually exclusive.
- `conf_word` and `divisor` are driven directly from flops, with no combinational path from inputs. Downstream muxes therefore see a single, glitch-free transition.

## Test plan

- After reset, `conf_word`=8'hE0 and `divisor`=8'd95. Send frame 16'h1042 → `conf_word`=8'h42 at ncs-rise+4 cycles, `conf_strobe` pulses once, `divisor` stays 95.
- Send frame 16'h2017 → `divisor`=8'h17, `div_strobe` pulses once. Send 16'h3055 → `cmd_err` pulses, neither register changes.
- Send a 15-bit frame and then a 20-bit frame ending in 16'h10A5 → `frame_err` pulses twice, `conf_word` unchanged.
- Hold ncs low through reset release, then clock in 16 bits and raise ncs → no update and no pulses. The next full frame 16'h1060 → `conf_word`=8'h60.
- Assert `nreset` after 9 bits of frame 16'h1011 → outputs return to reset values. After release, a full 16'h2003 → `divisor`=8'h03.
- Apply an spck rising edge in the same synchronized cycle as ncs rising, with 16 prior bits → the extra edge is ignored and the 16-bit command is applied.
